// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx32 among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to abort a frame whose busy never rises.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_data,
   output logic [NUM_REQ-1:0]    ack,
   output logic                  tx_start,
   output logic [31:0]           tx_data,
   input  logic                  tx_busy,
   output logic                  arb_busy,
   output logic [2:0]            grant_idx,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [NUM_REQ-1:0] r_ack;
   logic [31:0]        r_data;
   logic [2:0]         r_grant;
   logic               w_found;
   logic [2:0]         w_sel;
   logic [31:0]        w_word;

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
         $error("uart_tx_arbiter: parameter out of range");
      end
   endgenerate

   // Lowest rotated distance from the last grant wins.
   always_comb begin
      int v_best;
      int v_d;
      w_found = 1'b0;
      w_sel   = '0;
      w_word  = '0;
      v_best  = NUM_REQ;
      v_d     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         v_d = (i + 2 * NUM_REQ - int'(r_grant) - 1) % NUM_REQ;
         if (req[i] && v_d < v_best) begin
            v_best  = v_d;
            w_found = 1'b1;
            w_sel   = 3'(i);
            w_word  = req_data[32*i +: 32];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] r_cnt;
   logic          r_terr;
   logic          w_tmo;

   assign w_tmo = (r_state == S_WAIT_HI) && !tx_busy &&
                  (r_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_terr <= 1'b0;
      end else begin
         r_cnt  <= (r_state == S_WAIT_HI) ? r_cnt + 1'b1 : '0;
         r_terr <= w_tmo;
      end
   end

   assign timeout_err = r_terr;
`else
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_found) w_next = S_START;
         end
         S_START: begin
            w_next = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (tx_busy) w_next = S_WAIT_LO;
`ifdef UART_ARB_TIMEOUT_EN
            else if (w_tmo) w_next = S_IDLE;
`endif
         end
         S_WAIT_LO: begin
            if (!tx_busy) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_ack   <= '0;
         r_data  <= '0;
         r_grant <= 3'(NUM_REQ - 1);
      end else begin
         r_state <= w_next;
         r_ack   <= '0;
         if (r_state == S_IDLE && w_found) begin
            r_ack   <= NUM_REQ'(1) << w_sel;
            r_data  <= w_word;
            r_grant <= w_sel;
         end
      end
   end

   assign ack       = r_ack;
   assign tx_start  = (r_state == S_START);
   assign tx_data   = r_data;
   assign arb_busy  = (r_state != S_IDLE);
   assign grant_idx = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic
// scored against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*32-1:0] req_data = '0;
   logic [N-1:0]   ack;
   logic           tx_start;
   logic [31:0]    tx_data;
   logic           tx_busy;
   logic           arb_busy;
   logic [2:0]     grant_idx;
   logic           timeout_err;

   logic busy_auto  = 1'b0;
   logic busy_force = 1'b0;
   logic r_mb       = 1'b0;
   int   b_len      = 40;
   int   bc         = 0;

   int n_chk = 0;
   int n_err = 0;
   int ptr   = N - 1;

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .arb_busy    (arb_busy),
      .grant_idx   (grant_idx),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Transmitter stand-in: busy rises 1 cycle after start for b_len cycles.
   assign tx_busy = busy_auto ? r_mb : busy_force;

   always @(posedge clk) begin
      if (!busy_auto) begin
         r_mb <= 1'b0;
         bc   <= 0;
      end else if (tx_start) begin
         r_mb <= 1'b1;
         bc   <= b_len - 1;
      end else if (bc > 0) begin
         bc <= bc - 1;
      end else begin
         r_mb <= 1'b0;
      end
   end

   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      int j;
      for (int k = 1; k <= N; k++) begin
         j = (last + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      return N'(1) << i;
   endfunction

   task automatic do_reset();
      req        = '0;
      busy_auto  = 1'b0;
      busy_force = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ptr = N - 1;
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while ((arb_busy || tx_busy) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      if (arb_busy || tx_busy) begin
         n_err++;
         $display("FAIL wait_idle: arb_busy=%b tx_busy=%b after %0d cycles",
                  arb_busy, tx_busy, cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req = 3'b111;
      repeat (2) @(negedge clk);
      n_chk++;
      if (ack !== 3'b000) begin
         n_err++; $display("FAIL reset_ack: got %b want 000", ack);
      end
      n_chk++;
      if (tx_start !== 1'b0) begin
         n_err++; $display("FAIL reset_start: got %b want 0", tx_start);
      end
      n_chk++;
      if (arb_busy !== 1'b0) begin
         n_err++; $display("FAIL reset_arb_busy: got %b want 0", arb_busy);
      end
      n_chk++;
      if (tx_data !== 32'h0) begin
         n_err++; $display("FAIL reset_data: got %h want 0", tx_data);
      end
      n_chk++;
      if (grant_idx !== 3'd2) begin
         n_err++; $display("FAIL reset_grant: got %0d want 2", grant_idx);
      end
      n_chk++;
      if (timeout_err !== 1'b0) begin
         n_err++; $display("FAIL reset_tmo: got %b want 0", timeout_err);
      end
      req = '0;
      rst = 1'b1;
      ptr = N - 1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int cyc;
      int bad;
      bit hi;
      do_reset();
      busy_auto = 1'b1;
      b_len     = 40;
      req_data  = '0;
      req_data[63:32] = 32'hDEADBEEF;
      req = 3'b010;
      @(negedge clk);
      n_chk++;
      if (ack !== 3'b010 || tx_start !== 1'b1) begin
         n_err++;
         $display("FAIL single_ack: ack=%b start=%b want 010/1", ack, tx_start);
      end
      n_chk++;
      if (tx_data !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL single_data: got %h want deadbeef", tx_data);
      end
      n_chk++;
      if (grant_idx !== 3'd1) begin
         n_err++; $display("FAIL single_grant: got %0d want 1", grant_idx);
      end
      req = '0;
      hi  = 0;
      bad = 0;
      cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (tx_busy) hi = 1;
         else if (hi) break;
         if (tx_data !== 32'hDEADBEEF || !arb_busy) bad++;
      end
      n_chk++;
      if (!hi || tx_busy || cyc != 41) begin
         n_err++;
         $display("FAIL single_frame: busy fell after %0d cycles want 41", cyc);
      end
      n_chk++;
      if (bad != 0) begin
         n_err++; $display("FAIL single_hold: %0d bad cycles want 0", bad);
      end
      n_chk++;
      if (arb_busy !== 1'b1) begin
         n_err++; $display("FAIL single_lo1: arb_busy=%b want 1", arb_busy);
      end
      @(negedge clk);
      n_chk++;
      if (arb_busy !== 1'b0 || tx_data !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL single_lo2: arb_busy=%b data=%h want 0/deadbeef",
                  arb_busy, tx_data);
      end
   endtask

   task automatic test_round_robin();
      int order[4] = '{0, 1, 2, 0};
      int got;
      int cyc;
      int last;
      int exp;
      int n_ack;
      do_reset();
      busy_auto = 1'b1;
      b_len     = 6;
      for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'h11111111 * i;
      req   = 3'b111;
      got   = 0;
      cyc   = 0;
      last  = -1;
      n_ack = 0;
      while (got < 4 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (ack !== '0) n_ack++;
         if (tx_start === 1'b1) begin
            exp = rr_pick(ptr, req);
            ptr = exp;
            n_chk++;
            if (ack !== onehot(exp) || tx_data !== 32'h11111111 * exp) begin
               n_err++;
               $display("FAIL rr_word%0d: ack=%b data=%h want %b/%h", got,
                        ack, tx_data, onehot(exp), 32'h11111111 * exp);
            end
            n_chk++;
            if (grant_idx !== 3'(order[got])) begin
               n_err++;
               $display("FAIL rr_order%0d: got %0d want %0d", got,
                        grant_idx, order[got]);
            end
            if (last >= 0) begin
               n_chk++;
               if (cyc - last != b_len + 3) begin
                  n_err++;
                  $display("FAIL rr_spacing: got %0d want %0d",
                           cyc - last, b_len + 3);
               end
            end
            last = cyc;
            got++;
         end
      end
      n_chk++;
      if (got != 4 || n_ack != 4) begin
         n_err++;
         $display("FAIL rr_count: grants=%0d acks=%0d want 4/4", got, n_ack);
      end
      req = '0;
      wait_idle();
   endtask

   task automatic test_req_while_busy();
      int cyc;
      int bad;
      do_reset();
      busy_auto = 1'b1;
      b_len     = 8;
      req_data[31:0]  = 32'hA5A5A5A5;
      req_data[95:64] = 32'h0C0FFEE0;
      req = 3'b001;
      @(negedge clk);
      req = '0;
      cyc = 0;
      while (!tx_busy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      req = 3'b100;
      bad = 0;
      cyc = 0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (!arb_busy) break;
         if (ack !== '0) bad++;
      end
      n_chk++;
      if (bad != 0 || arb_busy !== 1'b0 || ack !== 3'b000) begin
         n_err++;
         $display("FAIL busy_noack: early acks=%0d ack=%b arb_busy=%b",
                  bad, ack, arb_busy);
      end
      @(negedge clk);
      n_chk++;
      if (ack !== 3'b100 || tx_data !== 32'h0C0FFEE0 || grant_idx !== 3'd2) begin
         n_err++;
         $display("FAIL busy_grant: ack=%b data=%h idx=%0d want 100/0c0ffee0/2",
                  ack, tx_data, grant_idx);
      end
      req = '0;
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int cyc;
      do_reset();
      busy_auto = 1'b1;
      b_len     = 20;
      req_data[31:0] = 32'h12345678;
      req = 3'b010;
      @(negedge clk);
      req = '0;
      cyc = 0;
      while (!tx_busy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      repeat (2) @(negedge clk);
      n_chk++;
      if (arb_busy !== 1'b1) begin
         n_err++; $display("FAIL mid_pre: arb_busy=%b want 1", arb_busy);
      end
      req = 3'b111;
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if (tx_start !== 1'b0 || ack !== 3'b000 || arb_busy !== 1'b0) begin
         n_err++;
         $display("FAIL mid_rst: start=%b ack=%b arb_busy=%b want 0",
                  tx_start, ack, arb_busy);
      end
      n_chk++;
      if (tx_data !== 32'h0 || grant_idx !== 3'd2) begin
         n_err++;
         $display("FAIL mid_rst_regs: data=%h idx=%0d want 0/2",
                  tx_data, grant_idx);
      end
      @(negedge clk);
      rst = 1'b1;
      ptr = N - 1;
      @(negedge clk);
      n_chk++;
      if (ack !== 3'b001 || tx_start !== 1'b1 || tx_data !== 32'h12345678) begin
         n_err++;
         $display("FAIL mid_first: ack=%b start=%b data=%h want 001/1/12345678",
                  ack, tx_start, tx_data);
      end
      req = '0;
      wait_idle();
   endtask

   task automatic test_timeout();
      int bad;
      do_reset();
      busy_auto  = 1'b0;
      busy_force = 1'b0;
      req = 3'b111;
      @(negedge clk);
      n_chk++;
      if (ack !== 3'b001) begin
         n_err++; $display("FAIL tmo_grant: ack=%b want 001", ack);
      end
      bad = 0;
`ifdef UART_ARB_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (timeout_err !== 1'b0 || arb_busy !== 1'b1) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_err++; $display("FAIL tmo_early: %0d bad cycles want 0", bad);
      end
      @(negedge clk);
      n_chk++;
      if (timeout_err !== 1'b1 || arb_busy !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_pulse: tmo=%b arb_busy=%b want 1/0",
                  timeout_err, arb_busy);
      end
      @(negedge clk);
      n_chk++;
      if (timeout_err !== 1'b0 || ack !== 3'b010 || tx_start !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_next: tmo=%b ack=%b start=%b want 0/010/1",
                  timeout_err, ack, tx_start);
      end
`else
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (timeout_err !== 1'b0 || arb_busy !== 1'b1 || ack !== '0) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_err++; $display("FAIL tmo_stuck: %0d bad cycles want 0", bad);
      end
`endif
      req = '0;
      do_reset();
   endtask

   task automatic test_random();
      bit          pend;
      int          exp;
      logic [31:0] expw;
      do_reset();
      busy_auto = 1'b1;
      pend = 0;
      exp  = 0;
      expw = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         n_chk++;
         if (pend) begin
            if (ack !== onehot(exp) || tx_start !== 1'b1 ||
                tx_data !== expw || grant_idx !== 3'(exp)) begin
               n_err++;
               $display("FAIL rand_grant@%0d: ack=%b data=%h idx=%0d want %b/%h/%0d",
                        cyc, ack, tx_data, grant_idx, onehot(exp), expw, exp);
            end
         end else if (ack !== '0 || tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL rand_quiet@%0d: ack=%b start=%b want 0/0",
                     cyc, ack, tx_start);
         end
         pend  = 0;
         b_len = $urandom_range(1, 6);
         if ($urandom_range(0, 3) == 0) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
         end
         if (!arb_busy && req != '0) begin
            exp  = rr_pick(ptr, req);
            ptr  = exp;
            expw = req_data[32*exp +: 32];
            pend = 1;
         end
      end
      req = '0;
      wait_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_req_while_busy();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
